lfsr_checker: RTL and testbench

- Receive end of the LFSR pattern generator.
- Accepts the generator's parallel output words, self-synchronises to the sequence, then predicts each next word.
- Flags mismatches, keeps a saturating error count and tracks lock status.
- Used in BIST loops and benches to verify the generator output and its transport path.

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_step.sv | 42 ++++
 rtl/lfsr_checker.sv | 153 +++++++++++++++
 tb/tb_lfsr_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR pattern generator and checker.
//   - state_t    : checker FSM encoding (SEARCH / VERIFY / LOCKED)
//   - lfsr_next  : one LFSR step, fb = ^(s & taps), next = {s[W-2:0], fb}
// The generator and the checker both call lfsr_next, so the two ends of a
// link can never disagree on the polynomial convention.
// -----------------------------------------------------------------------------
package lfsr_pkg;

  // Widest LFSR the shared step function supports. Callers zero-extend their
  // words to this width and keep only their own low bits of the result.
  localparam int LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Zero-extended inputs leave the upper bits of s and taps at 0, so the
  // feedback bit only depends on the caller's WIDTH low bits.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic fb;
    fb = ^(s & taps);
    return {s[LFSR_MAX_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Purely combinational single LFSR step: o_next = next(i_s) under i_taps.
// Ports:
//   i_s     in  WIDTH  current LFSR word
//   i_taps  in  WIDTH  feedback polynomial mask
//   o_next  out WIDTH  following LFSR word
// WIDTH must be in 2..LFSR_MAX_W.
// -----------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_taps,
  output logic [WIDTH-1:0] o_next
);

  logic [LFSR_MAX_W-1:0] w_s_ext;
  logic [LFSR_MAX_W-1:0] w_taps_ext;
  logic [LFSR_MAX_W-1:0] w_next_ext;

  always_comb begin
    w_s_ext                = '0;
    w_s_ext[WIDTH-1:0]     = i_s;
    w_taps_ext             = '0;
    w_taps_ext[WIDTH-1:0]  = i_taps;
  end

  assign w_next_ext = lfsr_next(w_s_ext, w_taps_ext);
  assign o_next     = w_next_ext[WIDTH-1:0];

  // Bits above WIDTH only carry the shifted-out top bit; nothing needs them.
  generate
    if (WIDTH < LFSR_MAX_W) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_next_ext[LFSR_MAX_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive end of the LFSR pattern generator. Self-synchronises to the incoming
// word stream, then predicts every next word, flags mismatches, keeps a
// saturating error count and reports lock status.
// Ports:
//   i_clk             in  1      system clock, rising edge
//   i_rst_n           in  1      asynchronous active-low reset
//   i_taps            in  WIDTH  feedback polynomial (static while locked)
//   i_data_in         in  WIDTH  received LFSR word
//   i_data_valid      in  1      i_data_in is sampled on this edge
//   i_clear_errors    in  1      synchronous clear of o_error_count
//   o_locked          out 1      FSM is in LOCKED
//   o_error           out 1      one-cycle pulse: last valid sample mismatched
//                                while locked
//   o_error_count     out CNT_W  saturating mismatch count while locked
//   o_expected_value  out WIDTH  prediction for the next valid sample
// -----------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_taps,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_data_valid,
  input  logic             i_clear_errors,
  output logic             o_locked,
  output logic             o_error,
  output logic [CNT_W-1:0] o_error_count,
  output logic [WIDTH-1:0] o_expected_value
);

  // LOCK_COUNT / UNLOCK_COUNT are limited to 1..15, so 4-bit counters suffice.
  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_COUNT);

  state_t           r_state;
  logic [3:0]       r_match;
  logic [3:0]       r_miss;
  logic             r_locked;
  logic             r_error;
  logic [CNT_W-1:0] r_error_count;
  logic [WIDTH-1:0] r_expected;

  logic [WIDTH-1:0] w_reseed_next;
  logic [WIDTH-1:0] w_fly_next;
  logic             w_hit;
  logic [3:0]       w_match_inc;
  logic [3:0]       w_miss_inc;
  logic             w_cnt_sat;

  // Reseed path: the prediction is rebuilt from the received word.
  lfsr_step #(.WIDTH(WIDTH)) u_step_reseed (
    .i_s    (i_data_in),
    .i_taps (i_taps),
    .o_next (w_reseed_next)
  );

  // Flywheel path: once locked, the prediction advances on its own so a
  // corrupted word on the link cannot drag the checker off the sequence.
  lfsr_step #(.WIDTH(WIDTH)) u_step_fly (
    .i_s    (r_expected),
    .i_taps (i_taps),
    .o_next (w_fly_next)
  );

  assign w_hit       = (i_data_in == r_expected);
  assign w_match_inc = r_match + 4'd1;
  assign w_miss_inc  = r_miss + 4'd1;
  assign w_cnt_sat   = &r_error_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= SEARCH;
      r_match       <= 4'd0;
      r_miss        <= 4'd0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
      r_error_count <= '0;
      r_expected    <= '0;
    end else begin
      // error is a pulse: low unless this edge flags a locked mismatch.
      r_error <= 1'b0;

      if (i_data_valid) begin
        case (r_state)
          SEARCH: begin
            // All-zero is the LFSR lock-up word and cannot seed a prediction.
            if (i_data_in != '0) begin
              r_expected <= w_reseed_next;
              r_match    <= 4'd0;
              r_state    <= VERIFY;
            end
          end

          VERIFY: begin
            // Hit or miss, the next prediction follows the received word.
            r_expected <= w_reseed_next;
            if (w_hit) begin
              r_match <= w_match_inc;
              if (w_match_inc == LOCK_CNT) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_miss   <= 4'd0;
              end
            end else begin
              r_match <= 4'd0;
            end
          end

          LOCKED: begin
            r_expected <= w_fly_next;
            if (w_hit) begin
              r_miss <= 4'd0;
            end else begin
              r_error <= 1'b1;
              if (!w_cnt_sat) begin
                r_error_count <= r_error_count + CNT_W'(1);
              end
              r_miss <= w_miss_inc;
              if (w_miss_inc == UNLOCK_CNT) begin
                r_state  <= SEARCH;
                r_locked <= 1'b0;
              end
            end
          end

          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end

      // Placed last so a clear overrides an increment on the same edge.
      if (i_clear_errors) begin
        r_error_count <= '0;
      end
    end
  end

  assign o_locked         = r_locked;
  assign o_error          = r_error;
  assign o_error_count    = r_error_count;
  assign o_expected_value = r_expected;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
// Directed bench for lfsr_checker with WIDTH=4, taps=4'b1100. Reference
// sequence (period 15) from 1111:
//   1111 1110 1100 1000 0001 0010 0100 1001 0011 0110 1101 1010 0101 1011 0111
// dut_a: default parameters (LOCK_COUNT=4, UNLOCK_COUNT=3, CNT_W=16).
// dut_b: CNT_W=2, UNLOCK_COUNT=15 for saturation and clear behaviour.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic [3:0]  taps;

  logic [3:0]  a_data;
  logic        a_valid;
  logic        a_clear;
  logic        a_locked;
  logic        a_error;
  logic [15:0] a_count;
  logic [3:0]  a_expected;

  logic [3:0]  b_data;
  logic        b_valid;
  logic        b_clear;
  logic        b_locked;
  logic        b_error;
  logic [1:0]  b_count;
  logic [3:0]  b_expected;

  int checks = 0;
  int errors = 0;

  lfsr_checker #(
    .WIDTH(4), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(16)
  ) dut_a (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_taps           (taps),
    .i_data_in        (a_data),
    .i_data_valid     (a_valid),
    .i_clear_errors   (a_clear),
    .o_locked         (a_locked),
    .o_error          (a_error),
    .o_error_count    (a_count),
    .o_expected_value (a_expected)
  );

  lfsr_checker #(
    .WIDTH(4), .LOCK_COUNT(4), .UNLOCK_COUNT(15), .CNT_W(2)
  ) dut_b (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_taps           (taps),
    .i_data_in        (b_data),
    .i_data_valid     (b_valid),
    .i_clear_errors   (b_clear),
    .o_locked         (b_locked),
    .o_error          (b_error),
    .o_error_count    (b_count),
    .o_expected_value (b_expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic lk, input logic er,
                         input logic [15:0] cnt, input logic [3:0] ex);
    check({tag, ".locked"},   32'(a_locked),   32'(lk));
    check({tag, ".error"},    32'(a_error),    32'(er));
    check({tag, ".count"},    32'(a_count),    32'(cnt));
    check({tag, ".expected"}, 32'(a_expected), 32'(ex));
  endtask

  task automatic check_b(input string tag, input logic lk, input logic er,
                         input logic [1:0] cnt, input logic [3:0] ex);
    check({tag, ".locked"},   32'(b_locked),   32'(lk));
    check({tag, ".error"},    32'(b_error),    32'(er));
    check({tag, ".count"},    32'(b_count),    32'(cnt));
    check({tag, ".expected"}, 32'(b_expected), 32'(ex));
  endtask

  // Apply one sample, wait for the edge, and sample outputs 1 time unit later.
  task automatic drive_a(input logic v, input logic [3:0] d, input logic clr);
    a_valid = v;
    a_data  = d;
    a_clear = clr;
    @(posedge clk);
    #1;
    $display("txn A valid=%b data=%b clr=%b -> locked=%b error=%b count=%0d expected=%b",
             v, d, clr, a_locked, a_error, a_count, a_expected);
  endtask

  task automatic drive_b(input logic v, input logic [3:0] d, input logic clr);
    b_valid = v;
    b_data  = d;
    b_clear = clr;
    @(posedge clk);
    #1;
    $display("txn B valid=%b data=%b clr=%b -> locked=%b error=%b count=%0d expected=%b",
             v, d, clr, b_locked, b_error, b_count, b_expected);
  endtask

  logic [1:0] sat_cnt [5];
  logic [3:0] sat_exp [5];

  initial begin
    sat_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sat_exp = '{4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101};

    taps    = 4'b1100;
    a_data  = 4'b0000; a_valid = 1'b0; a_clear = 1'b0;
    b_data  = 4'b0000; b_valid = 1'b0; b_clear = 1'b0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_a("reset", 1'b0, 1'b0, 16'd0, 4'b0000);
    #9 rst_n = 1'b1;

    // ---- dut_a: acquisition ------------------------------------------------
    drive_a(1'b1, 4'b0000, 1'b0); check_a("zero_in_search", 1'b0, 1'b0, 16'd0, 4'b0000);
    drive_a(1'b1, 4'b1111, 1'b0); check_a("seed",           1'b0, 1'b0, 16'd0, 4'b1110);
    drive_a(1'b1, 4'b1110, 1'b0); check_a("verify_hit1",    1'b0, 1'b0, 16'd0, 4'b1100);
    drive_a(1'b1, 4'b1100, 1'b0); check_a("verify_hit2",    1'b0, 1'b0, 16'd0, 4'b1000);
    drive_a(1'b1, 4'b1000, 1'b0); check_a("verify_hit3",    1'b0, 1'b0, 16'd0, 4'b0001);
    // Fourth consecutive hit after the seed word enters LOCKED.
    drive_a(1'b1, 4'b0001, 1'b0); check_a("lock",           1'b1, 1'b0, 16'd0, 4'b0010);
    drive_a(1'b1, 4'b0010, 1'b0); check_a("locked_hit",     1'b1, 1'b0, 16'd0, 4'b0100);

    // ---- single corrupted word -------------------------------------------
    drive_a(1'b1, 4'b0101, 1'b0); check_a("single_err",     1'b1, 1'b1, 16'd1, 4'b1001);
    drive_a(1'b1, 4'b1001, 1'b0); check_a("after_err",      1'b1, 1'b0, 16'd1, 4'b0011);

    // ---- valid gap holds everything --------------------------------------
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 4'b1010, 1'b0); check_a("gap", 1'b1, 1'b0, 16'd1, 4'b0011);
    end
    drive_a(1'b1, 4'b0011, 1'b1); check_a("resume_clear",   1'b1, 1'b0, 16'd0, 4'b0110);

    // ---- loss of lock after three misses ---------------------------------
    drive_a(1'b1, 4'b0000, 1'b0); check_a("miss1",          1'b1, 1'b1, 16'd1, 4'b1101);
    drive_a(1'b1, 4'b0000, 1'b0); check_a("miss2",          1'b1, 1'b1, 16'd2, 4'b1010);
    drive_a(1'b1, 4'b0000, 1'b0); check_a("miss3_unlock",   1'b0, 1'b1, 16'd3, 4'b0101);
    drive_a(1'b1, 4'b0000, 1'b0); check_a("search_zero",    1'b0, 1'b0, 16'd3, 4'b0101);
    drive_a(1'b1, 4'b1011, 1'b0); check_a("reseed",         1'b0, 1'b0, 16'd3, 4'b0111);
    drive_a(1'b1, 4'b0111, 1'b0); check_a("verify_hit",     1'b0, 1'b0, 16'd3, 4'b1111);
    // A miss in VERIFY reseeds silently and restarts the match count.
    drive_a(1'b1, 4'b0001, 1'b0); check_a("verify_miss",    1'b0, 1'b0, 16'd3, 4'b0010);
    drive_a(1'b1, 4'b0010, 1'b0); check_a("relock_h1",      1'b0, 1'b0, 16'd3, 4'b0100);
    drive_a(1'b1, 4'b0100, 1'b0); check_a("relock_h2",      1'b0, 1'b0, 16'd3, 4'b1001);
    drive_a(1'b1, 4'b1001, 1'b0); check_a("relock_h3",      1'b0, 1'b0, 16'd3, 4'b0011);
    drive_a(1'b1, 4'b0011, 1'b0); check_a("relock",         1'b1, 1'b0, 16'd3, 4'b0110);
    drive_a(1'b1, 4'b0000, 1'b0); check_a("pre_reset_err",  1'b1, 1'b1, 16'd4, 4'b1101);

    // ---- asynchronous reset between edges --------------------------------
    a_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_a("async_reset", 1'b0, 1'b0, 16'd0, 4'b0000);
    #1 rst_n = 1'b1;
    drive_a(1'b1, 4'b1111, 1'b0); check_a("post_reset_seed", 1'b0, 1'b0, 16'd0, 4'b1110);
    drive_a(1'b1, 4'b1110, 1'b0);
    drive_a(1'b1, 4'b1100, 1'b0);
    drive_a(1'b1, 4'b1000, 1'b0);
    drive_a(1'b1, 4'b0001, 1'b0); check_a("post_reset_lock", 1'b1, 1'b0, 16'd0, 4'b0010);
    a_valid = 1'b0;

    // ---- dut_b: saturation and clear -------------------------------------
    drive_b(1'b1, 4'b1111, 1'b0);
    drive_b(1'b1, 4'b1110, 1'b0);
    drive_b(1'b1, 4'b1100, 1'b0);
    drive_b(1'b1, 4'b1000, 1'b0); check_b("b_pre_lock", 1'b0, 1'b0, 2'd0, 4'b0001);
    drive_b(1'b1, 4'b0001, 1'b0); check_b("b_lock",     1'b1, 1'b0, 2'd0, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      drive_b(1'b1, 4'b0000, 1'b0); check_b("b_sat_miss", 1'b1, 1'b1, sat_cnt[i], sat_exp[i]);
    end
    drive_b(1'b1, 4'b0000, 1'b1); check_b("b_clear_vs_miss",  1'b1, 1'b1, 2'd0, 4'b1010);
    drive_b(1'b1, 4'b0000, 1'b0); check_b("b_count_after_clr", 1'b1, 1'b1, 2'd1, 4'b0101);
    drive_b(1'b0, 4'b0000, 1'b1); check_b("b_clear_idle",     1'b1, 1'b0, 2'd0, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
